spi_dac_mc: RTL
===============

SPI_DAC_MC -- requirements
Module: spi_dac_mc

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, DAC sample width in bits (range 8..24).
REQ-002 The block SHALL have parameter CHAN_N, default 4, number of DAC channels (range 1..16).
REQ-003 The block SHALL have parameter CLK_DIV, default 2, mclk cycles per sclk half-period (range 1..255).
REQ-004 The block SHALL have parameter LDAC_MODE, default 0: 0 = ldac_n pulse after every frame; 1 = pulse only after a frame whose beat carried s_axis_last=1.
REQ-005 The block SHALL have derived constants CHAN_W = max(1, clog2(CHAN_N)) and FRAME_W = DATA_W + 8.
REQ-006 The block SHALL have port mclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 The block SHALL have port en, input, 1 bit: enables acceptance of new samples.
REQ-009 The block SHALL have port s_axis_valid, input, 1 bit: sample beat valid.
REQ-010 The block SHALL have port s_axis_ready, output, 1 bit: block accepts a beat.
REQ-011 The block SHALL have port s_axis_data, input, DATA_W bits: DAC code.
REQ-012 The block SHALL have port s_axis_chan, input, CHAN_W bits: target channel.
REQ-013 The block SHALL have port s_axis_last, input, 1 bit: final beat of a simultaneous-update group.
REQ-014 The block SHALL have port sclk, output, 1 bit: SPI clock, idle low.
REQ-015 The block SHALL have port mosi, output, 1 bit: SPI data, MSB first.
REQ-016 The block SHALL have port cs_n, output, 1 bit: SPI chip select, active low.
REQ-017 The block SHALL have port ldac_n, output, 1 bit: DAC load strobe, active low.
REQ-018 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-019 The block SHALL have port err_chan, output, 1 bit: one-cycle pulse when a beat with s_axis_chan >= CHAN_N is consumed.
REQ-020 The block SHALL have port frame_cnt, output, 16 bits: count of transmitted frames, wrapping 0xFFFF->0x0000.

Function
REQ-021 The block SHALL be controlled by an FSM with states IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP, LDAC.
REQ-022 In IDLE, s_axis_ready SHALL equal en; in every other state, and whenever rst_n=0, it SHALL be 0.
REQ-023 On a handshake (valid & ready) with a legal channel, the block SHALL latch frame = {4'b0001, chan zero-extended to 4 bits, data}, and on the next cycle cs_n SHALL be 0, mosi = frame[FRAME_W-1], and state = CS_SETUP.
REQ-024 On a handshake with an illegal channel, the beat SHALL be dropped, err_chan SHALL pulse on the next cycle, state SHALL remain IDLE, and frame_cnt SHALL be unchanged.
REQ-025 CS_SETUP SHALL last CLK_DIV cycles with sclk=0.
REQ-026 SHIFT SHALL produce FRAME_W sclk periods, each CLK_DIV cycles low followed by CLK_DIV cycles high.
REQ-027 mosi SHALL change only at the start of a low phase, in the cycle after the sclk falling edge, and SHALL be stable throughout each high phase.
REQ-028 After the last high phase, sclk SHALL return to 0 and CS_HOLD SHALL last CLK_DIV cycles with cs_n=0, mosi unchanged.
REQ-029 The cs_n low time SHALL be exactly CLK_DIV*(2*FRAME_W+2) mclk cycles.
REQ-030 On exit from CS_HOLD, cs_n SHALL go to 1, mosi SHALL go to 0, frame_cnt SHALL increment, and state = GAP.
REQ-031 GAP SHALL last CLK_DIV cycles; then, if an update is pending, state = LDAC, otherwise IDLE.
REQ-032 In LDAC_MODE=0 an update SHALL always be pending; in LDAC_MODE=1 an update SHALL be pending only if the latched s_axis_last = 1.
REQ-033 LDAC SHALL hold ldac_n=0 for CLK_DIV cycles, then return to IDLE with ldac_n=1.
REQ-034 The minimum spacing between cs_n rising and the next cs_n falling SHALL be CLK_DIV+1 cycles without an update pulse, and 2*CLK_DIV+1 cycles with one.
REQ-035 Deasserting en mid-frame SHALL NOT abort the frame; the current frame and its LDAC SHALL complete, and no further beats SHALL be accepted.
REQ-036 Input signals changing while busy SHALL have no effect.
REQ-037 The sclk half-period counter and the bit counter SHALL be internal, sized for CLK_DIV and FRAME_W, and reloaded on every state entry.

Reset
REQ-038 While rst_n=0 at a clock edge, the block SHALL set state=IDLE, sclk=0, mosi=0, cs_n=1, ldac_n=1, s_axis_ready=0, busy=0, err_chan=0, frame_cnt=0, and clear all counters and pending flags.
REQ-039 A reset asserted mid-frame SHALL abort the frame in that cycle with no ldac_n pulse, and frame_cnt SHALL NOT be incremented.
REQ-040 After rst_n rises, s_axis_ready SHALL assert on the first cycle if en=1.

Verification
REQ-041 Bench scenario (defaults): beat data=0xCAFE, chan=2 -> 24 sclk rising edges; mosi sampled on the rising edges = 0x12CAFE; cs_n low 100 cycles; ldac_n low 2 cycles; frame_cnt=1.
REQ-042 Bench scenario (LDAC_MODE=1): beats 0xBEEF ch0 last=0, 0xFACE ch1 last=0, 0xC0DE ch3 last=1 -> three frames 0x10BEEF, 0x11FACE, 0x13C0DE; exactly one ldac_n pulse, after the third frame.
REQ-043 Bench scenario (illegal channel): CHAN_N=3, beat chan=3 -> no cs_n activity, err_chan high exactly 1 cycle, ready remains high.
REQ-044 Bench scenario (reset mid-frame): rst_n low at the 10th sclk edge -> next cycle cs_n=1, sclk=0, ldac_n=1; the following beat transmits a full correct frame.
REQ-045 Bench scenario (CLK_DIV=1, continuous valid): back-to-back frames with cs_n low exactly 50 cycles and cs_n rise-to-fall spacing of 3 cycles; checker sees no missed or duplicated beats over 70000 frames, and frame_cnt wraps correctly.
REQ-046 Bench scenario (en gating): en dropped mid-frame -> the frame completes with ldac_n, ready stays 0, and the next beat is accepted only after en returns.

Source files
------------

// File: rtl/spi_dac_mc.sv
// Multi-channel SPI DAC serializer: a stream beat becomes one 8+DATA_W bit SPI frame, optionally followed by an ldac_n strobe.
// cs_n falls the cycle after the handshake; s_axis_ready is only high while idle and enabled.
module spi_dac_mc #(
    parameter int DATA_W    = 16,
    parameter int CHAN_N    = 4,
    parameter int CLK_DIV   = 2,
    parameter int LDAC_MODE = 0,
    localparam int CHAN_W   = (CHAN_N > 1) ? $clog2(CHAN_N) : 1,
    localparam int FRAME_W  = DATA_W + 8
) (
    input  logic              mclk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              s_axis_valid,
    output logic              s_axis_ready,
    input  logic [DATA_W-1:0] s_axis_data,
    input  logic [CHAN_W-1:0] s_axis_chan,
    input  logic              s_axis_last,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              ldac_n,
    output logic              busy,
    output logic              err_chan,
    output logic [15:0]       frame_cnt
);

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP, LDAC} state_t;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
    localparam logic [CHAN_W:0]  CHAN_LIM = CHAN_N[CHAN_W:0];

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic                last_q, last_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                cs_n_q, cs_n_d;
    logic                ldac_n_q, ldac_n_d;
    logic                err_chan_q, err_chan_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic                take;
    logic                chan_ok;
    logic                div_done;
    logic [FRAME_W-1:0]  frame_in;

    assign s_axis_ready = rst_n & en & (state_q == IDLE);
    assign take         = s_axis_valid & s_axis_ready;
    assign chan_ok      = {1'b0, s_axis_chan} < CHAN_LIM;
    assign div_done     = (div_q == '0);
    assign frame_in     = {4'b0001, 4'(s_axis_chan), s_axis_data};

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        frame_d     = frame_q;
        last_d      = last_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        ldac_n_d    = ldac_n_q;
        err_chan_d  = 1'b0;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    if (chan_ok) begin
                        state_d = CS_SETUP;
                        frame_d = frame_in;
                        last_d  = s_axis_last;
                        cs_n_d  = 1'b0;
                        mosi_d  = frame_in[FRAME_W-1];
                        div_d   = DIV_LAST;
                    end else begin
                        err_chan_d = 1'b1;
                    end
                end
            end
            CS_SETUP: begin
                if (div_done) begin
                    state_d = SHIFT;
                    div_d   = DIV_LAST;
                    bit_d   = BIT_LAST;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            SHIFT: begin
                if (!div_done) begin
                    div_d = div_q - 1'b1;
                end else begin
                    div_d = DIV_LAST;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        // Next bit is presented together with the falling edge, so it is settled a full low phase before sampling.
                        if (bit_q == '0) begin
                            state_d = CS_HOLD;
                        end else begin
                            bit_d   = bit_q - 1'b1;
                            frame_d = frame_q << 1;
                            mosi_d  = frame_q[FRAME_W-2];
                        end
                    end
                end
            end
            CS_HOLD: begin
                if (div_done) begin
                    state_d     = GAP;
                    cs_n_d      = 1'b1;
                    mosi_d      = 1'b0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    div_d       = DIV_LAST;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            GAP: begin
                if (div_done) begin
                    if ((LDAC_MODE == 0) || last_q) begin
                        state_d  = LDAC;
                        ldac_n_d = 1'b0;
                        div_d    = DIV_LAST;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            LDAC: begin
                if (div_done) begin
                    state_d  = IDLE;
                    ldac_n_d = 1'b1;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            frame_q     <= '0;
            last_q      <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            ldac_n_q    <= 1'b1;
            err_chan_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            frame_q     <= frame_d;
            last_q      <= last_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            ldac_n_q    <= ldac_n_d;
            err_chan_q  <= err_chan_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign cs_n      = cs_n_q;
    assign ldac_n    = ldac_n_q;
    assign busy      = (state_q != IDLE);
    assign err_chan  = err_chan_q;
    assign frame_cnt = frame_cnt_q;

endmodule
